uart_rx: RTL

//  Serial receive half of the 8N1 UART link. Recovers bytes from the raw pad input i_rx_unsafe and buffers them in a small FIFO.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_fifo.sv | 91 +++++++++
 rtl/uart_rx.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM encoding, data width and baud divisor helper.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    // Clocks per bit period, truncated.
    function automatic int unsigned clocks_per_baud(input int unsigned clock_freq,
                                                    input int unsigned baud);
        return clock_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO with a registered head entry and registered empty/full flags.
// A push while full is dropped unless a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_head;
    logic             r_empty;
    logic             r_full;

    logic             w_do_push;
    logic             w_do_pop;
    logic [AW-1:0]    w_rd_ptr_p1;
    logic [CW-1:0]    w_count_nxt;
    logic [WIDTH-1:0] w_head_nxt;

    assign w_do_pop    = i_pop & ~r_empty;
    assign w_do_push   = i_push & (~r_full | w_do_pop);
    assign w_rd_ptr_p1 = r_rd_ptr + AW'(1);

    always_comb begin
        w_count_nxt = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_do_push && w_do_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Next head: the entry behind the popped one, or the incoming byte when it lands at the head.
    always_comb begin
        w_head_nxt = r_head;
        if (w_do_pop) begin
            if (r_count == CW'(1)) begin
                w_head_nxt = w_do_push ? i_push_data : r_head;
            end else begin
                w_head_nxt = r_mem[w_rd_ptr_p1];
            end
        end else if (r_empty && w_do_push) begin
            w_head_nxt = i_push_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_ptr_p1;
            end
            r_count <= w_count_nxt;
            r_head  <= w_head_nxt;
            r_empty <= (w_count_nxt == CW'(0));
            r_full  <= (w_count_nxt == CW'(DEPTH));
        end
    end

    assign o_head_data = r_head;
    assign o_empty     = r_empty;
    assign o_full      = r_full;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, baud counter, frame FSM and shift register feeding a byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames with parity checking; otherwise frames are 8N1.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 16_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_rx_unsafe,
    output logic [UART_DATA_BITS-1:0] o_read_data,
    output logic                      o_rx_valid,
    input  logic                      i_read_enable,
    output logic                      o_frame_err,
    output logic                      o_overrun,
    output logic                      o_parity_err
);

    localparam int unsigned CLOCKS_PER_BAUD = clocks_per_baud(CLOCK_FREQ, BAUD);
    localparam int unsigned HALF_BAUD       = CLOCKS_PER_BAUD / 2;
    localparam int unsigned CNT_W           = $clog2(CLOCKS_PER_BAUD);
    localparam int unsigned BIT_W           = $clog2(UART_DATA_BITS);

    logic                      r_sync1;
    logic                      r_rx_s;
    rx_state_t                 r_state;
    rx_state_t                 w_state_nxt;
    logic [CNT_W-1:0]          r_cnt;
    logic [BIT_W-1:0]          r_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_frame_err;
    logic                      r_overrun;

    logic                      w_mid;
    logic                      w_bit_end;
    logic                      w_last_bit;
    logic                      w_cnt_clr;
    logic                      w_idx_clr;
    logic                      w_shift_en;
    logic                      w_push;
    logic                      w_frame_err;
    logic                      w_pop;
    logic                      w_fifo_empty;
    logic                      w_fifo_full;
    logic [UART_DATA_BITS-1:0] w_fifo_head;
`ifdef UART_RX_PARITY_EN
    logic                      r_par_bad;
    logic                      r_parity_err;
    logic                      w_par_err;
`endif

    // Line idles high, so the synchroniser resets to 1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= i_rx_unsafe;
            r_rx_s  <= r_sync1;
        end
    end

    assign w_mid      = (r_cnt == CNT_W'(HALF_BAUD));
    assign w_bit_end  = (r_cnt == CNT_W'(CLOCKS_PER_BAUD - 1));
    assign w_last_bit = (r_bit_idx == BIT_W'(UART_DATA_BITS - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RX_IDLE:  if (!r_rx_s) w_state_nxt = RX_START;
            RX_START: if (w_mid) w_state_nxt = r_rx_s ? RX_IDLE : RX_DATA;
`ifdef UART_RX_PARITY_EN
            RX_DATA:   if (w_bit_end && w_last_bit) w_state_nxt = RX_PARITY;
            RX_PARITY: if (w_bit_end) w_state_nxt = RX_STOP;
`else
            RX_DATA:   if (w_bit_end && w_last_bit) w_state_nxt = RX_STOP;
`endif
            RX_STOP:  if (w_bit_end) w_state_nxt = RX_IDLE;
            default:  w_state_nxt = RX_IDLE;
        endcase
    end

    // Samples fall on the half-bit count in START and on the full-bit count afterwards.
    always_comb begin
        w_cnt_clr   = 1'b0;
        w_idx_clr   = 1'b0;
        w_shift_en  = 1'b0;
        w_push      = 1'b0;
        w_frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_err   = 1'b0;
`endif
        case (r_state)
            RX_IDLE: begin
                w_cnt_clr = 1'b1;
                w_idx_clr = 1'b1;
            end
            RX_START: begin
                w_cnt_clr = w_mid;
                w_idx_clr = w_mid;
            end
            RX_DATA: begin
                w_cnt_clr  = w_bit_end;
                w_shift_en = w_bit_end;
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                w_cnt_clr = w_bit_end;
                w_par_err = w_bit_end & ((^r_shift) ^ r_rx_s);
            end
            RX_STOP: begin
                w_cnt_clr   = w_bit_end;
                w_push      = w_bit_end & r_rx_s & ~r_par_bad;
                w_frame_err = w_bit_end & ~r_rx_s;
            end
`else
            RX_STOP: begin
                w_cnt_clr   = w_bit_end;
                w_push      = w_bit_end & r_rx_s;
                w_frame_err = w_bit_end & ~r_rx_s;
            end
`endif
            default: w_cnt_clr = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_cnt <= w_cnt_clr ? CNT_W'(0) : r_cnt + CNT_W'(1);
            if (w_idx_clr) begin
                r_bit_idx <= '0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + BIT_W'(1);
            end
            if (w_shift_en) begin
                r_shift <= {r_rx_s, r_shift[UART_DATA_BITS-1:1]};
            end
        end
    end

    assign w_pop = i_read_enable & ~w_fifo_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err;
            r_overrun   <= w_push & w_fifo_full & ~w_pop;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Bad parity is remembered so the stop bit is still checked but the byte is not stored.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_par_err;
            if (r_state == RX_IDLE) begin
                r_par_bad <= 1'b0;
            end else if (w_par_err) begin
                r_par_bad <= 1'b1;
            end
        end
    end

    assign o_parity_err = r_parity_err;
`else
    assign o_parity_err = 1'b0;
`endif

    uart_rx_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (w_push),
        .i_push_data (r_shift),
        .i_pop       (w_pop),
        .o_head_data (w_fifo_head),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full)
    );

    assign o_read_data = w_fifo_head;
    assign o_rx_valid  = ~w_fifo_empty;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;

endmodule
